// File: rtl/warp_pkg.sv
// Shared types and constants for the texture-warp pixel copy engine.
// State encoding, widths and default raster/texture geometry.
package warp_pkg;

    localparam int PIX_W   = 16;
    localparam int CNT_W   = 22;
    localparam int COORD_W = 11;

    localparam int DEF_HRES  = 640;
    localparam int DEF_VRES  = 480;
    localparam int DEF_TEX_W = 512;
    localparam int DEF_TEX_H = 512;

    typedef enum logic [2:0] {
        IDLE,
        WAITPIX,
        FETCH,
        WRITE,
        ADVANCE,
        HOLDOFF
    } state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/warp_pixel_copy_if.sv
// Control, rasterizer stream and memory port bundle of the copy engine.
// master = copy engine, slave = rasterizer/memory/host side.
interface warp_pixel_copy_if #(parameter int AW = 22);
    import warp_pkg::*;

    logic                 start;
    logic [AW-1:0]        src_base;
    logic [AW-1:0]        dst_base;
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
    logic [COORD_W-1:0]   u;
    logic [COORD_W-1:0]   v;
    logic                 ready;
    logic                 finished;
    logic                 next;
    logic [AW-1:0]        src_addr;
    logic                 src_req;
    logic                 src_ack;
    logic [PIX_W-1:0]     src_data;
    logic [AW-1:0]        dst_addr;
    logic [PIX_W-1:0]     dst_data;
    logic                 dst_we;
    logic                 dst_ack;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     written;
    logic [CNT_W-1:0]     skipped;

    modport master (
        input  start, src_base, dst_base,
        input  x, y, u, v, ready, finished,
        input  src_ack, src_data, dst_ack,
        output next, src_addr, src_req,
        output dst_addr, dst_data, dst_we,
        output busy, done, written, skipped
    );

    modport slave (
        output start, src_base, dst_base,
        output x, y, u, v, ready, finished,
        output src_ack, src_data, dst_ack,
        input  next, src_addr, src_req,
        input  dst_addr, dst_data, dst_we,
        input  busy, done, written, skipped
    );

endinterface

// File: rtl/warp_addr_gen.sv
// Combinational base + row*WIDTH + col word-address generator.
// Coordinates beyond the surface clamp to its last row/column.
module warp_addr_gen
    import warp_pkg::*;
#(
    parameter int AW     = 22,
    parameter int WIDTH  = 512,
    parameter int HEIGHT = 512
) (
    input  logic [AW-1:0]      base,
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    output logic [AW-1:0]      addr
);

    localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(HEIGHT - 1);

    logic [COORD_W-1:0] colc;
    logic [COORD_W-1:0] rowc;

    // Clamp to the edge, then linearise; the sum wraps silently at AW bits.
    always_comb begin
        colc = (col > COL_MAX) ? COL_MAX : col;
        rowc = (row > ROW_MAX) ? ROW_MAX : row;
        addr = base + AW'(rowc) * AW'(WIDTH) + AW'(colc);
    end

endmodule

// File: rtl/warp_pixel_copy.sv
// Rasterizer output consumer: copies one texel per pixel from the
// source texture to the framebuffer and drops off-screen pixels.
module warp_pixel_copy
    import warp_pkg::*;
#(
    parameter int HRES  = DEF_HRES,
    parameter int VRES  = DEF_VRES,
    parameter int TEX_W = DEF_TEX_W,
    parameter int TEX_H = DEF_TEX_H,
    parameter int AW    = 22
) (
    input  logic               clk,
    input  logic               rst_n,
    warp_pixel_copy_if.master  bus
);

    state_t             state;
    logic [AW-1:0]      src_base_q;
    logic [AW-1:0]      dst_base_q;
    logic [AW-1:0]      src_nxt;
    logic [AW-1:0]      dst_nxt;
    logic               on_screen;

    logic               next_q;
    logic [AW-1:0]      src_addr_q;
    logic               src_req_q;
    logic [AW-1:0]      dst_addr_q;
    logic [PIX_W-1:0]   dst_data_q;
    logic               dst_we_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   written_q;
    logic [CNT_W-1:0]   skipped_q;

    warp_addr_gen #(
        .AW     (AW),
        .WIDTH  (TEX_W),
        .HEIGHT (TEX_H)
    ) u_src_gen (
        .base (src_base_q),
        .row  (bus.v),
        .col  (bus.u),
        .addr (src_nxt)
    );

    warp_addr_gen #(
        .AW     (AW),
        .WIDTH  (HRES),
        .HEIGHT (VRES)
    ) u_dst_gen (
        .base (dst_base_q),
        .row  (bus.y),
        .col  (bus.x),
        .addr (dst_nxt)
    );

    // Screen bounds test on the raw pixel coordinates.
    always_comb begin
        on_screen = (bus.x < COORD_W'(HRES)) && (bus.y < COORD_W'(VRES));
    end

    // Main sequencer: one pixel at a time, all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            src_base_q <= '0;
            dst_base_q <= '0;
            next_q     <= 1'b0;
            src_addr_q <= '0;
            src_req_q  <= 1'b0;
            dst_addr_q <= '0;
            dst_data_q <= '0;
            dst_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            written_q  <= '0;
            skipped_q  <= '0;
        end else begin
            next_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start && !done_q) begin
                        src_base_q <= bus.src_base;
                        dst_base_q <= bus.dst_base;
                        written_q  <= '0;
                        skipped_q  <= '0;
                        busy_q     <= 1'b1;
                        state      <= WAITPIX;
                    end
                end
                WAITPIX: begin
                    if (bus.ready) begin
                        if (!on_screen) begin
                            skipped_q <= sat_inc(skipped_q);
                            next_q    <= 1'b1;
                            state     <= ADVANCE;
                        end else begin
                            src_addr_q <= src_nxt;
                            dst_addr_q <= dst_nxt;
                            src_req_q  <= 1'b1;
                            state      <= FETCH;
                        end
                    end else if (bus.finished) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                FETCH: begin
                    if (bus.src_ack) begin
                        src_req_q  <= 1'b0;
                        dst_data_q <= bus.src_data;
                        dst_we_q   <= 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    if (bus.dst_ack) begin
                        dst_we_q  <= 1'b0;
                        written_q <= sat_inc(written_q);
                        next_q    <= 1'b1;
                        state     <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    state <= HOLDOFF;
                end
                HOLDOFF: begin
                    state <= WAITPIX;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.next     = next_q;
    assign bus.src_addr = src_addr_q;
    assign bus.src_req  = src_req_q;
    assign bus.dst_addr = dst_addr_q;
    assign bus.dst_data = dst_data_q;
    assign bus.dst_we   = dst_we_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.written  = written_q;
    assign bus.skipped  = skipped_q;

endmodule

// File: doc/warp_pixel_copy.md
# warp_pixel_copy

Pixel-stream consumer at the output end of the triangle rasterizer in the texture-warp pipeline. It takes the rasterizer's (x,y,u,v) stream and drives its `next` handshake. For each pixel it reads one texel from the source texture at (u,v) and writes it to the destination framebuffer at (x,y). It reports completion once the rasterizer signals `finished`.

## Interface
- HRES, 640, destination framebuffer width in pixels
- VRES, 480, destination framebuffer height in pixels
- TEX_W, 512, source texture width in texels
- TEX_H, 512, source texture height in texels
- AW, 22, memory word-address width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  one-cycle arm pulse; ignored while busy
- src_base, dst_base  in  AW each  texture and framebuffer base word addresses, sampled on start
- x, y, u, v  in  11 each  current pixel from rasterizer, valid while ready=1
- ready  in  1  rasterizer holds a valid pixel
- finished  in  1  rasterizer has no more pixels
- next  out  1  one-cycle pulse: consume current pixel
- src_addr  out  AW  texel read address
- src_req  out  1  read request, held until src_ack
- src_ack  in  1  read complete; src_data valid this cycle
- src_data  in  16  RGB565 texel
- dst_addr  out  AW  framebuffer write address
- dst_data  out  16  pixel to write
- dst_we  out  1  write request, held until dst_ack
- dst_ack  in  1  write accepted
- busy  out  1  armed and processing
- done  out  1  one-cycle pulse on completion
- written  out  22  count of pixels written since last start
- skipped  out  22  count of off-screen pixels dropped since last start

## Operation
- States: IDLE, WAITPIX, FETCH, WRITE, ADVANCE, HOLDOFF.
- IDLE: start=1 latches the bases, clears written/skipped, sets busy, and goes to WAITPIX.
- WAITPIX:
  - ready=1 with x>=HRES or y>=VRES: skipped+1, go to ADVANCE, no memory access.
  - ready=1 otherwise: latch the pixel and go to FETCH.
  - ready=0 and finished=1: pulse done, clear busy, go to IDLE.
  - If ready=1 and finished=1 in the same cycle, ready has priority.
- FETCH:
  - src_addr = src_base + vc*TEX_W + uc.
  - uc = min(u, TEX_W-1) and vc = min(v, TEX_H-1); out-of-range texture coordinates clamp to the edge.
  - src_req is held high. On src_ack, register src_data and go to WRITE.
- WRITE:
  - dst_addr = dst_base + y*HRES + x, dst_data = registered texel, dst_we held high.
  - On dst_ack: written+1, go to ADVANCE.
- ADVANCE: next=1 for exactly this cycle, then go to HOLDOFF.
- HOLDOFF: one dead cycle, so that a stale ready is never resampled. Then go to WAITPIX.
- Arithmetic: address sums are truncated to AW bits; the wrap is silent. Counters saturate at 2^22-1.
- Reset mid-operation: all state returns to the reset values at once. Any outstanding src_req or dst_we is dropped, with no completion.

## Timing
- Reset values: next=0, src_req=0, dst_we=0, src_addr=0, dst_addr=0, dst_data=0, busy=0, done=0, written=0, skipped=0, state=IDLE.
- All outputs are registered.
- start to busy=1: 1 cycle.
- Per written pixel, with zero-wait memory (ack in the first request cycle): 5 cycles from ready sampled to the next WAITPIX. Each cycle of ack delay adds one.
- Skipped pixel: 3 cycles (WAITPIX, ADVANCE, HOLDOFF).
- Address and data outputs are stable for the whole time src_req or dst_we is high.
- done is asserted the cycle after WAITPIX sees finished=1, ready=0. busy falls in the same cycle.
- start is ignored while busy=1; a start coinciding with done is also ignored.

## Structure
- Shared package warp_pkg holds the state encoding, the RGB565 width constant (16), and the default HRES/VRES/TEX_W/TEX_H values.
- One sub-module, warp_addr_gen: a combinational base + row*WIDTH + col generator with clamping. It is instantiated twice, once for source and once for destination.

## Test plan
- Single pixel, zero-wait memory:
  - Stimulus: start, src_base=0x1000, dst_base=0x20000, pixel (x=3,y=2,u=5,v=1), src_data=0xF800.
  - Required: src_addr=0x1000+1*512+5=0x1205; dst_addr=0x20000+2*640+3=0x20503 with data 0xF800.
  - Required: one next pulse, then done after finished; written=1.
- Off-screen skip: pixel x=700, y=10 -> no src_req or dst_we, one next pulse, skipped=1.
- Clamp: u=600, v=520 -> src_addr = src_base + 511*512 + 511.
- Backpressure: src_ack delayed 4 cycles and dst_ack delayed 3 -> address and data held stable throughout; exactly one write.
- Stream of 100 pixels plus finished:
  - Required: written=100, 100 next pulses, and next never pulses two cycles apart.
  - Required: start pulses issued during the run are ignored.
- rst_n low during FETCH -> all outputs at their reset values immediately; a new start after release processes normally.
